dmem_responder: RTL

- Responder end of the CPU data-memory request interface. Serves word-granular read/write requests from the MEM stage and drives busy/done/rdata back to it.
- Each request becomes a sequence of byte beats on an 8-bit synchronous-RAM port (one byte per cycle, 1-cycle read latency).
- Sits between the MEM-stage initiator and the on-chip byte-wide data RAM.

---
 rtl/dmem_responder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Responder for word read/write requests from the MEM stage, serialised into byte beats on a byte-wide synchronous RAM.
// Optional DMEM_BYTE_SKIP_EN: writes visit only enabled byte lanes.
module dmem_responder #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [3:0]        req_sel,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_LAST = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  logic [1:0]          r_k;
  logic [ADDR_W-3:0]   r_waddr;
  logic [3:0]          r_sel;
  logic [31:0]         r_wdata;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_rdata;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [7:0]          r_ram_wdata;

  logic [1:0]          w_k_inc;
  logic [ADDR_W-3:0]   w_req_waddr;
  logic                w_unused_addr;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

`ifdef DMEM_BYTE_SKIP_EN
  // Returns {found, index} of the lowest set bit of mask.
  function automatic logic [2:0] first_lane(input logic [3:0] mask);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  logic [2:0] w_acc_lane;
  logic [2:0] w_nxt_lane;
  assign w_acc_lane = first_lane(req_sel);
  assign w_nxt_lane = first_lane(r_sel & (4'b1110 << r_k));
`endif

  assign w_k_inc       = r_k + 2'd1;
  assign w_req_waddr   = req_addr[ADDR_W-1:2];
  assign w_unused_addr = ^{req_addr[31:ADDR_W], req_addr[1:0]};

  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

  // Transaction FSM; every output is registered alongside the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= 2'd0;
      r_waddr     <= '0;
      r_sel       <= 4'd0;
      r_wdata     <= 32'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= 32'd0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (req_re) begin
            r_state    <= S_RD;
            r_k        <= 2'd0;
            r_waddr    <= w_req_waddr;
            r_busy     <= 1'b1;
            r_ram_en   <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= {w_req_waddr, 2'b00};
          end else if (req_we) begin
            r_waddr <= w_req_waddr;
            r_sel   <= req_sel;
            r_wdata <= req_wdata;
`ifdef DMEM_BYTE_SKIP_EN
            if (w_acc_lane[2]) begin
              r_state     <= S_WR;
              r_k         <= w_acc_lane[1:0];
              r_busy      <= 1'b1;
              r_ram_en    <= 1'b1;
              r_ram_we    <= 1'b1;
              r_ram_addr  <= {w_req_waddr, w_acc_lane[1:0]};
              r_ram_wdata <= lane_byte(req_wdata, w_acc_lane[1:0]);
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
`else
            r_state     <= S_WR;
            r_k         <= 2'd0;
            r_busy      <= 1'b1;
            r_ram_en    <= 1'b1;
            r_ram_we    <= req_sel[0];
            r_ram_addr  <= {w_req_waddr, 2'b00};
            r_ram_wdata <= req_wdata[7:0];
`endif
          end
        end

        S_RD: begin
          // The byte requested in the previous beat is on ram_rdata now.
          if (r_k != 2'd0) begin
            r_rdata[{r_k - 2'd1, 3'b000} +: 8] <= ram_rdata;
          end
          if (r_k == 2'd3) begin
            r_state  <= S_RD_LAST;
            r_ram_en <= 1'b0;
          end else begin
            r_k        <= w_k_inc;
            r_ram_addr <= {r_waddr, w_k_inc};
          end
        end

        S_RD_LAST: begin
          r_rdata[31:24] <= ram_rdata;
          r_state        <= S_DONE;
          r_busy         <= 1'b0;
          r_done         <= 1'b1;
        end

        S_WR: begin
`ifdef DMEM_BYTE_SKIP_EN
          if (w_nxt_lane[2]) begin
            r_k         <= w_nxt_lane[1:0];
            r_ram_we    <= 1'b1;
            r_ram_addr  <= {r_waddr, w_nxt_lane[1:0]};
            r_ram_wdata <= lane_byte(r_wdata, w_nxt_lane[1:0]);
          end else begin
            r_state  <= S_DONE;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
`else
          if (r_k == 2'd3) begin
            r_state  <= S_DONE;
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_k         <= w_k_inc;
            r_ram_we    <= r_sel[w_k_inc];
            r_ram_addr  <= {r_waddr, w_k_inc};
            r_ram_wdata <= lane_byte(r_wdata, w_k_inc);
          end
`endif
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule
